// File: rtl/way_replace_ctrl.sv
// Per-set replacement controller: victim select, dirty writeback, refill and LRU recency update.
// Optional perf counters are built only when REPL_PERF_CNT_EN is defined.
module way_replace_ctrl #(
    parameter int WAYS     = 4,
    parameter int WAY_BITS = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_hit,
    input  logic [WAY_BITS-1:0] req_hit_way,
    input  logic [WAYS-1:0]     valid_vec,
    input  logic [WAYS-1:0]     dirty_vec,
    input  logic [WAYS-1:0]     lru_vec,
    output logic [WAY_BITS-1:0] lru_access,
    output logic                lru_access_vld,
    output logic [WAY_BITS-1:0] victim_way,
    output logic                wb_req,
    input  logic                wb_ack,
    output logic                fill_req,
    input  logic                fill_ack,
    output logic                done,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
    output logic [31:0]         wb_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SELECT    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_UPDATE    = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [WAY_BITS-1:0] r_victim_way;
    logic                r_done;
    logic [WAY_BITS-1:0] w_inv_way;
    logic [WAY_BITS-1:0] w_lru_way;
    logic [WAY_BITS-1:0] w_sel_way;
    logic                w_sel_dirty;

    // Downward scan leaves the lowest matching index; an empty lru_vec falls back to way 0.
    always_comb begin
        w_inv_way = '0;
        w_lru_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) w_inv_way = WAY_BITS'(i);
            if (lru_vec[i])    w_lru_way = WAY_BITS'(i);
        end
        w_sel_way   = (&valid_vec) ? w_lru_way : w_inv_way;
        w_sel_dirty = valid_vec[w_sel_way] & dirty_vec[w_sel_way];
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next_state = req_hit ? S_UPDATE : S_SELECT;
            end
            S_SELECT:    w_next_state = w_sel_dirty ? S_WRITEBACK : S_FILL;
            S_WRITEBACK: if (wb_ack) w_next_state = S_FILL;
            S_FILL:      if (fill_ack) w_next_state = S_UPDATE;
            S_UPDATE:    w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // done/lru_access_vld are registered off UPDATE so they land one cycle after it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_victim_way <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == S_UPDATE);
            if (r_state == S_IDLE && req_valid && req_hit) begin
                r_victim_way <= req_hit_way;
            end else if (r_state == S_SELECT) begin
                r_victim_way <= w_sel_way;
            end
        end
    end

    assign req_ready      = (r_state == S_IDLE);
    assign wb_req         = (r_state == S_WRITEBACK);
    assign fill_req       = (r_state == S_FILL);
    assign done           = r_done;
    assign lru_access_vld = r_done;
    assign lru_access     = r_victim_way;
    assign victim_way     = r_victim_way;

`ifdef REPL_PERF_CNT_EN
    logic        w_hit_accept;
    logic        w_miss_accept;
    logic        w_wb_accept;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic [31:0] r_wb_cnt;

    assign w_hit_accept  = (r_state == S_IDLE) && req_valid && req_hit;
    assign w_miss_accept = (r_state == S_IDLE) && req_valid && !req_hit;
    assign w_wb_accept   = (r_state == S_WRITEBACK) && wb_ack;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_wb_cnt   <= '0;
        end else begin
            if (w_hit_accept && r_hit_cnt != 32'hFFFF_FFFF)   r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss_accept && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            if (w_wb_accept && r_wb_cnt != 32'hFFFF_FFFF)     r_wb_cnt   <= r_wb_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
    assign wb_cnt   = r_wb_cnt;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
    assign wb_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_way_replace_ctrl.sv
// Self-checking bench for way_replace_ctrl: directed scenarios plus randomized hit/miss traffic
// checked against a transaction-level reference (victim rule, latencies, counters).
module tb_way_replace_ctrl;

    localparam int WAYS     = 4;
    localparam int WAY_BITS = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic                req_hit;
    logic [WAY_BITS-1:0] req_hit_way;
    logic [WAYS-1:0]     valid_vec;
    logic [WAYS-1:0]     dirty_vec;
    logic [WAYS-1:0]     lru_vec;
    logic [WAY_BITS-1:0] lru_access;
    logic                lru_access_vld;
    logic [WAY_BITS-1:0] victim_way;
    logic                wb_req;
    logic                wb_ack;
    logic                fill_req;
    logic                fill_ack;
    logic                done;
    logic [31:0]         hit_cnt;
    logic [31:0]         miss_cnt;
    logic [31:0]         wb_cnt;

    int nVectors     = 0;
    int nMiscompares = 0;
    int expHits      = 0;
    int expMisses    = 0;
    int expWbs       = 0;

    way_replace_ctrl #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_hit(req_hit), .req_hit_way(req_hit_way),
        .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_vec(lru_vec),
        .lru_access(lru_access), .lru_access_vld(lru_access_vld),
        .victim_way(victim_way),
        .wb_req(wb_req), .wb_ack(wb_ack),
        .fill_req(fill_req), .fill_ack(fill_ack),
        .done(done),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clock = ~clock;

    // Hard stop in case something upstream goes badly wrong.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Victim rule: lowest invalid way, else lowest LRU bit, else way 0 (isolate lowest bit via x & -x).
    function automatic int refVictim(input int valid, input int lru);
        int mask = (1 << WAYS) - 1;
        int inv  = (~valid) & mask;
        int l    = lru & mask;
        if (inv != 0) return $clog2(inv & -inv);
        if (l != 0)   return $clog2(l & -l);
        return 0;
    endfunction

    task automatic checkCounters(input string tag);
`ifdef REPL_PERF_CNT_EN
        checkOutput({tag, ".hit_cnt"}, hit_cnt, expHits);
        checkOutput({tag, ".miss_cnt"}, miss_cnt, expMisses);
        checkOutput({tag, ".wb_cnt"}, wb_cnt, expWbs);
`else
        checkOutput({tag, ".hit_cnt"}, hit_cnt, 32'd0);
        checkOutput({tag, ".miss_cnt"}, miss_cnt, 32'd0);
        checkOutput({tag, ".wb_cnt"}, wb_cnt, 32'd0);
`endif
    endtask

    // Starts in an IDLE cycle, ends in the done cycle (which is IDLE again).
    task automatic applyHit(input int way, input bit noise);
        checkOutput("hit.ready", req_ready, 1);
        req_valid   = 1'b1;
        req_hit     = 1'b1;
        req_hit_way = WAY_BITS'(way);
        wb_ack      = noise ? 1'($urandom % 2) : 1'b0;
        fill_ack    = noise ? 1'($urandom % 2) : 1'b0;
        tick();
        req_valid = 1'b0;
        wb_ack    = 1'b0;
        fill_ack  = 1'b0;
        expHits++;
        checkOutput("hit.busy", req_ready, 0);
        checkOutput("hit.early_done", done, 0);
        checkOutput("hit.no_wb", wb_req, 0);
        tick();
        checkOutput("hit.done", done, 1);
        checkOutput("hit.lru_vld", lru_access_vld, 1);
        checkOutput("hit.lru_access", lru_access, way);
        checkOutput("hit.victim", victim_way, way);
        checkOutput("hit.ready_after", req_ready, 1);
        checkCounters("hit");
    endtask

    // Full miss transaction; holdWay >= 0 holds a hit request during FILL; abortInFill resets mid-FILL.
    task automatic applyMiss(input int valid, input int dirty, input int lru,
                             input int wbDelay, input int fillDelay,
                             input int holdWay, input bit abortInFill);
        int  v;
        bit  isDirty;
        checkOutput("miss.ready", req_ready, 1);
        req_valid   = 1'b1;
        req_hit     = 1'b0;
        req_hit_way = WAY_BITS'($urandom);
        valid_vec   = WAYS'(valid);
        dirty_vec   = WAYS'(dirty);
        lru_vec     = WAYS'(lru);
        tick();
        req_valid = 1'b0;
        expMisses++;
        v       = refVictim(valid, lru);
        isDirty = (((valid >> v) & (dirty >> v)) & 1) != 0;
        wb_ack   = 1'($urandom % 2);
        fill_ack = 1'($urandom % 2);
        checkOutput("miss.busy", req_ready, 0);
        checkOutput("miss.sel_no_wb", wb_req, 0);
        checkOutput("miss.sel_no_fill", fill_req, 0);
        tick();
        wb_ack    = 1'b0;
        fill_ack  = 1'b0;
        valid_vec = WAYS'($urandom);
        dirty_vec = WAYS'($urandom);
        lru_vec   = WAYS'($urandom);
        checkOutput("miss.victim", victim_way, v);
        if (isDirty) begin
            for (int k = 0; k <= wbDelay; k++) begin
                checkOutput("miss.wb_req", wb_req, 1);
                checkOutput("miss.wb_no_fill", fill_req, 0);
                wb_ack   = (k == wbDelay);
                fill_ack = 1'($urandom % 2);
                tick();
            end
            wb_ack   = 1'b0;
            fill_ack = 1'b0;
            expWbs++;
        end else begin
            checkOutput("miss.clean_no_wb", wb_req, 0);
        end
        for (int k = 0; k <= fillDelay; k++) begin
            checkOutput("miss.fill_req", fill_req, 1);
            checkOutput("miss.fill_no_wb", wb_req, 0);
            if (abortInFill) begin
                #2 reset = 1'b1;
                #1;
                checkOutput("abort.fill_req", fill_req, 0);
                checkOutput("abort.ready", req_ready, 1);
                checkOutput("abort.done", done, 0);
                checkOutput("abort.lru_vld", lru_access_vld, 0);
                expHits   = 0;
                expMisses = 0;
                expWbs    = 0;
                return;
            end
            fill_ack = (k == fillDelay);
            wb_ack   = 1'($urandom % 2);
            if (holdWay >= 0) begin
                req_valid   = 1'b1;
                req_hit     = 1'b1;
                req_hit_way = WAY_BITS'(holdWay);
                checkOutput("miss.hold_ignored", req_ready, 0);
            end
            tick();
        end
        fill_ack = 1'b0;
        wb_ack   = 1'b0;
        checkOutput("miss.upd_no_fill", fill_req, 0);
        checkOutput("miss.upd_no_done", done, 0);
        checkOutput("miss.upd_busy", req_ready, 0);
        tick();
        checkOutput("miss.done", done, 1);
        checkOutput("miss.lru_vld", lru_access_vld, 1);
        checkOutput("miss.lru_access", lru_access, v);
        checkOutput("miss.ready_after", req_ready, 1);
        checkCounters("miss");
    endtask

    // Randomized traffic: mix of hits and misses with random vectors, delays and stray acks.
    task automatic applyStimulus(input int count);
        int lru;
        int hold;
        for (int n = 0; n < count; n++) begin
            if ($urandom % 3 == 0) begin
                applyHit(int'($urandom % WAYS), 1'b1);
            end else begin
                lru  = ($urandom % 2 == 0) ? (1 << ($urandom % WAYS)) : int'($urandom % 16);
                hold = ($urandom % 4 == 0) ? int'($urandom % WAYS) : -1;
                applyMiss(int'($urandom % 16), int'($urandom % 16), lru,
                          int'($urandom % 4), int'($urandom % 4), hold, 1'b0);
                if (hold >= 0) applyHit(hold, 1'b0);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_hit     = 1'b0;
        req_hit_way = '0;
        valid_vec   = '0;
        dirty_vec   = '0;
        lru_vec     = '0;
        wb_ack      = 1'b0;
        fill_ack    = 1'b0;
        tick();
        tick();
        checkOutput("rst.ready", req_ready, 1);
        checkOutput("rst.wb_req", wb_req, 0);
        checkOutput("rst.fill_req", fill_req, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.lru_vld", lru_access_vld, 0);
        checkOutput("rst.victim", victim_way, 0);
        checkOutput("rst.lru_access", lru_access, 0);
        checkCounters("rst");
        reset = 1'b0;
        tick();

        applyHit(2, 1'b0);
        applyMiss(4'b1011, 4'b1111, 4'b0001, 0, 1, -1, 1'b0);
        applyMiss(4'b1111, 4'b0100, 4'b0100, 2, 0, -1, 1'b0);
        applyMiss(4'b1111, 4'b0000, 4'b0000, 0, 0, -1, 1'b0);
        applyMiss(4'b1111, 4'b0000, 4'b1010, 0, 0, -1, 1'b0);

        // Stray acks while IDLE must not move the controller.
        wb_ack   = 1'b1;
        fill_ack = 1'b1;
        tick();
        wb_ack   = 1'b0;
        fill_ack = 1'b0;
        checkOutput("idle_ack.ready", req_ready, 1);
        checkOutput("idle_ack.wb_req", wb_req, 0);
        checkOutput("idle_ack.fill_req", fill_req, 0);
        tick();
        checkOutput("idle_ack.done", done, 0);

        applyMiss(4'b1111, 4'b0000, 4'b1000, 0, 2, 3, 1'b0);
        applyHit(3, 1'b0);

        applyMiss(4'b0111, 4'b0000, 4'b0001, 0, 2, -1, 1'b1);
        tick();
        checkOutput("abort.held_ready", req_ready, 1);
        checkOutput("abort.held_vld", lru_access_vld, 0);
        reset = 1'b0;
        tick();
        checkOutput("abort.post_vld", lru_access_vld, 0);
        checkOutput("abort.post_fill", fill_req, 0);
        checkCounters("abort");
        applyHit(1, 1'b0);

        applyStimulus(60);
        checkCounters("final");

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
